ascon_decrypt_fsm: RTL and testbench
====================================

Name: ascon_decrypt_fsm

Overview:
- Control FSM for ASCON-128 decryption.
- Sequences the shared permutation datapath (permutation register, begin-XOR stage, end-XOR stage) through four phases: initialisation, associated data, ciphertext, and finalisation/tag check.
- It is the decrypt-side counterpart of the encryption controller. Its main difference is the ciphertext handling: the begin stage replaces S0 with C and outputs P = S0 ^ C.
- Sits between the host block interface and the datapath; it drives only control signals, and no 320-bit state passes through it.

Parameters:
- NB_AD_BLOCKS, 1, number of 64-bit associated-data blocks per message (>= 1).
- NB_CT_BLOCKS, 4, number of 64-bit ciphertext blocks, last block included (>= 1).

Ports:
- clock_i  in  1  system clock.
- resetb_i  in  1  asynchronous reset, active low.
- start_i  in  1  one-cycle pulse that begins a message; honoured only in IDLE.
- data_valid_i  in  1  host presents an AD or CT block on the datapath data bus.
- tag_match_i  in  1  datapath comparator result: received tag == computed tag.
- data_ready_o  out  1  FSM accepts a block; transfer occurs when data_valid_i & data_ready_o.
- enable_o  out  1  permutation register enable.
- input_mode_o  out  1  0 = load IV||K||N, 1 = feedback.
- round_o  out  4  round-constant index.
- bypass_xor_begin_o  out  1  1 = no begin XOR.
- sel_xor_begin_o  out  2  begin-XOR operation:
  - 00 = S0 ^= A
  - 01 = S0 <- C
  - 11 = S0 <- C plus S1,S2 ^= K
- bypass_xor_end_o  out  1  1 = no end XOR.
- sel_xor_end_o  out  1  end-XOR operation: 0 = S3,S4 ^= K; 1 = S4 ^= 1 (domain separation).
- pt_valid_o  out  1  plaintext S0 ^ C is valid on the datapath output this cycle.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when the tag verdict is available.
- auth_ok_o  out  1  registered tag verdict, held until the next accepted start_i.

Behaviour:
- States: IDLE, INIT, AD_WAIT, AD_RUN, CT_WAIT, CT_RUN, FINAL, TAG.
- Outputs are decoded from state, round counter and handshake (Mealy in the WAIT states). auth_ok_o is the only registered output.
- Reset (asynchronous, any state, including mid-message):
  - state = IDLE, round counter = 0, block counter = 0.
  - auth_ok_o = 0.
  - All other outputs 0, except bypass_xor_begin_o = 1 and bypass_xor_end_o = 1.
- Defaults in every cycle not listed below: enable_o = 0, both bypass = 1, sel = 0, pt_valid_o = 0.
- IDLE:
  - start_i moves to INIT and clears auth_ok_o.
  - data_valid_i is ignored.
- INIT: 12 cycles, enable_o = 1, round_o = 0..11.
  - input_mode_o = 0 in the first cycle only, 1 afterwards.
  - Last cycle: bypass_xor_end_o = 0, sel_xor_end_o = 0 (key XOR).
  - Then go to AD_WAIT.
- AD_WAIT:
  - data_ready_o = 1.
  - On transfer, the transfer cycle is round 6: enable_o = 1, bypass_xor_begin_o = 0, sel_xor_begin_o = 00. Then go to AD_RUN.
  - Without transfer, enable_o = 0 and everything stalls indefinitely.
- AD_RUN: rounds 7..11 (5 cycles).
  - On round 11 of the last AD block: bypass_xor_end_o = 0, sel_xor_end_o = 1.
  - Next state: AD_WAIT if more AD blocks remain, else CT_WAIT.
- CT_WAIT:
  - data_ready_o = 1.
  - On transfer: pt_valid_o = 1, enable_o = 1, bypass_xor_begin_o = 0.
  - Non-last block: sel_xor_begin_o = 01, round_o = 6, go to CT_RUN (rounds 7..11, then back to CT_WAIT).
  - Last block (block count = NB_CT_BLOCKS-1): sel_xor_begin_o = 11, round_o = 0, go to FINAL.
- FINAL: rounds 1..11 (11 cycles).
  - Round 11: bypass_xor_end_o = 0, sel_xor_end_o = 0 (tag ends up in S3,S4).
- TAG: one cycle, enable_o = 0.
  - done_o = 1; auth_ok_o <= tag_match_i.
  - Then IDLE.
- Block counter:
  - Width $clog2(max(NB_AD_BLOCKS, NB_CT_BLOCKS)+1).
  - Cleared on entry to INIT and again on entry to CT_WAIT from AD_RUN.
  - Incremented on each transfer; it never wraps.
- start_i outside IDLE is ignored. data_valid_i outside the WAIT states is ignored.
- NB_CT_BLOCKS = 1: the first CT transfer is the last block and goes straight to FINAL.
- Latency:
  - start_i edge to data_ready_o = 12 cycles.
  - Each non-last block = 6 cycles.
  - Last CT transfer to done_o = 12 cycles.

Decomposition:
- ascon_pack additions:
  - state enum type_state_dec.
  - localparams ROUNDS_A = 12, ROUND_B_START = 6, LAST_ROUND = 11.
  - sel_xor_begin codes XB_AD = 2'b00, XB_CT = 2'b01, XB_CT_KEY = 2'b11.
  - sel_xor_end codes XE_KEY = 1'b0, XE_DS = 1'b1.
- Sub-module round_counter: 4-bit, asynchronous active-low reset. Synchronous load of 0 or 6 plus increment-enable, so the FSM only issues load/increment commands.

Test Plan:
- Nominal, NB_AD=1, NB_CT=4, data_valid_i held at 1, start_i at cycle 0:
  - INIT rounds 0..11 in cycles 1..12, with input_mode_o = 0 only in cycle 1 and end key XOR in cycle 12.
  - AD transfer in cycle 13 (round 6); domain separation at cycle 18.
  - CT transfers at 19, 25, 31 with sel 01; the last at 37 with sel 11 and round 0.
  - FINAL key XOR at 48; done_o at 49; pt_valid_o exactly 4 pulses.
- Stall: drop data_valid_i for 5 cycles in CT_WAIT:
  - enable_o = 0 and round_o frozen during the stall.
  - Resuming yields identical output sequences shifted by 5.
- Tag verdict: tag_match_i = 1 in TAG gives auth_ok_o = 1.
  - Next start_i clears it to 0.
  - A second run with tag_match_i = 0 gives auth_ok_o = 0 and done_o still pulses.
- Asynchronous reset mid-FINAL (round 5): all outputs take their reset values immediately; a following start_i re-runs the nominal sequence.
- NB_CT_BLOCKS = 1, NB_AD_BLOCKS = 2:
  - Two domain-free AD passes, then domain separation on the second.
  - The first CT transfer uses sel 11 and goes to FINAL.
- start_i pulsed during AD_RUN and data_valid_i pulsed during INIT: no state or output change.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared ASCON control definitions: decrypt FSM states, round bounds and XOR-stage select codes.
`default_nettype none
package ascon_pack;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_AD_WAIT = 3'd2,
    ST_AD_RUN  = 3'd3,
    ST_CT_WAIT = 3'd4,
    ST_CT_RUN  = 3'd5,
    ST_FINAL   = 3'd6,
    ST_TAG     = 3'd7
  } type_state_dec;

  localparam int         ROUNDS_A      = 12;
  localparam logic [3:0] ROUND_B_START = 4'd6;
  localparam logic [3:0] LAST_ROUND    = 4'(ROUNDS_A - 1);

  localparam logic [1:0] XB_AD     = 2'b00;
  localparam logic [1:0] XB_CT     = 2'b01;
  localparam logic [1:0] XB_CT_KEY = 2'b11;

  localparam logic XE_KEY = 1'b0;
  localparam logic XE_DS  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ascon_decrypt_fsm_round_counter.sv
// 4-bit permutation round counter: synchronous load of 0 or 6, otherwise optional increment.
`default_nettype none
module round_counter
  import ascon_pack::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       load_six,
  input  logic       incr,
  output logic [3:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_six ? ROUND_B_START : 4'd0;
    end else if (incr) begin
      count <= count + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ascon_decrypt_fsm.sv
// ASCON-128 decryption controller: sequences init, AD, ciphertext and finalisation/tag-check phases.
`default_nettype none
module ascon_decrypt_fsm
  import ascon_pack::*;
#(
  parameter int NB_AD_BLOCKS = 1,
  parameter int NB_CT_BLOCKS = 4
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic       tag_match_i,
  output logic       data_ready_o,
  output logic       enable_o,
  output logic       input_mode_o,
  output logic [3:0] round_o,
  output logic       bypass_xor_begin_o,
  output logic [1:0] sel_xor_begin_o,
  output logic       bypass_xor_end_o,
  output logic       sel_xor_end_o,
  output logic       pt_valid_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       auth_ok_o
);

  localparam int MAX_BLOCKS = (NB_AD_BLOCKS > NB_CT_BLOCKS) ? NB_AD_BLOCKS : NB_CT_BLOCKS;
  localparam int BLK_W      = $clog2(MAX_BLOCKS + 1);

  type_state_dec    state, state_next;
  logic [BLK_W-1:0] blk_cnt;
  logic [3:0]       round;
  logic             rc_load, rc_six, rc_inc;
  logic             blk_clr, blk_inc;
  logic             auth_clr, auth_set;
  logic             xfer, ct_last, ad_last;

  round_counter u_round_counter (
    .clk      (clock_i),
    .rst_n    (resetb_i),
    .load     (rc_load),
    .load_six (rc_six),
    .incr     (rc_inc),
    .count    (round)
  );

  assign round_o = round;
  assign busy_o  = (state != ST_IDLE);
  assign xfer    = data_valid_i & data_ready_o;
  assign ct_last = (blk_cnt == BLK_W'(NB_CT_BLOCKS - 1));
  assign ad_last = (blk_cnt >= BLK_W'(NB_AD_BLOCKS));

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Saturating so a misconfigured host can never wrap back onto a "last block" match.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      blk_cnt <= '0;
    end else if (blk_clr) begin
      blk_cnt <= '0;
    end else if (blk_inc && (blk_cnt != BLK_W'(MAX_BLOCKS))) begin
      blk_cnt <= blk_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      auth_ok_o <= 1'b0;
    end else if (auth_clr) begin
      auth_ok_o <= 1'b0;
    end else if (auth_set) begin
      auth_ok_o <= tag_match_i;
    end
  end

  always_comb begin
    state_next         = state;
    rc_load            = 1'b0;
    rc_six             = 1'b0;
    rc_inc             = 1'b0;
    blk_clr            = 1'b0;
    blk_inc            = 1'b0;
    auth_clr           = 1'b0;
    auth_set           = 1'b0;
    data_ready_o       = 1'b0;
    enable_o           = 1'b0;
    input_mode_o       = 1'b0;
    bypass_xor_begin_o = 1'b1;
    sel_xor_begin_o    = XB_AD;
    bypass_xor_end_o   = 1'b1;
    sel_xor_end_o      = XE_KEY;
    pt_valid_o         = 1'b0;
    done_o             = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_next = ST_INIT;
          rc_load    = 1'b1;
          blk_clr    = 1'b1;
          auth_clr   = 1'b1;
        end
      end

      ST_INIT: begin
        enable_o     = 1'b1;
        input_mode_o = (round != 4'd0);
        if (round == LAST_ROUND) begin
          bypass_xor_end_o = 1'b0;
          sel_xor_end_o    = XE_KEY;
          rc_load          = 1'b1;
          rc_six           = 1'b1;
          state_next       = ST_AD_WAIT;
        end else begin
          rc_inc = 1'b1;
        end
      end

      ST_AD_WAIT: begin
        data_ready_o = 1'b1;
        if (xfer) begin
          enable_o           = 1'b1;
          input_mode_o       = 1'b1;
          bypass_xor_begin_o = 1'b0;
          sel_xor_begin_o    = XB_AD;
          rc_inc             = 1'b1;
          blk_inc            = 1'b1;
          state_next         = ST_AD_RUN;
        end
      end

      ST_AD_RUN: begin
        enable_o     = 1'b1;
        input_mode_o = 1'b1;
        if (round == LAST_ROUND) begin
          rc_load = 1'b1;
          if (ad_last) begin
            bypass_xor_end_o = 1'b0;
            sel_xor_end_o    = XE_DS;
            blk_clr          = 1'b1;
            // A single-block ciphertext goes straight to the key-absorbing pass starting at round 0.
            rc_six           = (NB_CT_BLOCKS != 1);
            state_next       = ST_CT_WAIT;
          end else begin
            rc_six     = 1'b1;
            state_next = ST_AD_WAIT;
          end
        end else begin
          rc_inc = 1'b1;
        end
      end

      ST_CT_WAIT: begin
        data_ready_o = 1'b1;
        if (xfer) begin
          pt_valid_o         = 1'b1;
          enable_o           = 1'b1;
          input_mode_o       = 1'b1;
          bypass_xor_begin_o = 1'b0;
          rc_inc             = 1'b1;
          blk_inc            = 1'b1;
          if (ct_last) begin
            sel_xor_begin_o = XB_CT_KEY;
            state_next      = ST_FINAL;
          end else begin
            sel_xor_begin_o = XB_CT;
            state_next      = ST_CT_RUN;
          end
        end
      end

      ST_CT_RUN: begin
        enable_o     = 1'b1;
        input_mode_o = 1'b1;
        if (round == LAST_ROUND) begin
          rc_load    = 1'b1;
          rc_six     = !ct_last;
          state_next = ST_CT_WAIT;
        end else begin
          rc_inc = 1'b1;
        end
      end

      ST_FINAL: begin
        enable_o     = 1'b1;
        input_mode_o = 1'b1;
        if (round == LAST_ROUND) begin
          bypass_xor_end_o = 1'b0;
          sel_xor_end_o    = XE_KEY;
          rc_load          = 1'b1;
          state_next       = ST_TAG;
        end else begin
          rc_inc = 1'b1;
        end
      end

      ST_TAG: begin
        done_o     = 1'b1;
        auth_set   = 1'b1;
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ascon_decrypt_fsm.sv
// Self-checking bench: scripted message phases with random stalls/ignored pulses for two configurations.
`default_nettype none
module tb_ascon_decrypt_fsm;

  logic clk = 1'b0;
  logic rst_n, start_a, start_b, valid, tagm;

  logic       ready_a, en_a, mode_a, bb_a, be_a, se_a, pt_a, busy_a, done_a, auth_a;
  logic [3:0] round_a;
  logic [1:0] sb_a;
  logic       ready_b, en_b, mode_b, bb_b, be_b, se_b, pt_b, busy_b, done_b, auth_b;
  logic [3:0] round_b;
  logic [1:0] sb_b;

  int total = 0;
  int bad   = 0;
  logic use_b = 1'b0;
  logic aborted;

  // Observation vector: ready,en,mode,round[4],bb,sb[2],be,se,pt,busy,done,auth
  localparam logic [15:0] M_FULL = 16'hFFFF;
  localparam logic [15:0] M_IDLE = 16'hC1FF;

  always #5 clk = ~clk;

  ascon_decrypt_fsm #(.NB_AD_BLOCKS(1), .NB_CT_BLOCKS(4)) dut_a (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start_a), .data_valid_i(valid),
    .tag_match_i(tagm), .data_ready_o(ready_a), .enable_o(en_a), .input_mode_o(mode_a),
    .round_o(round_a), .bypass_xor_begin_o(bb_a), .sel_xor_begin_o(sb_a),
    .bypass_xor_end_o(be_a), .sel_xor_end_o(se_a), .pt_valid_o(pt_a),
    .busy_o(busy_a), .done_o(done_a), .auth_ok_o(auth_a)
  );

  ascon_decrypt_fsm #(.NB_AD_BLOCKS(2), .NB_CT_BLOCKS(1)) dut_b (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start_b), .data_valid_i(valid),
    .tag_match_i(tagm), .data_ready_o(ready_b), .enable_o(en_b), .input_mode_o(mode_b),
    .round_o(round_b), .bypass_xor_begin_o(bb_b), .sel_xor_begin_o(sb_b),
    .bypass_xor_end_o(be_b), .sel_xor_end_o(se_b), .pt_valid_o(pt_b),
    .busy_o(busy_b), .done_o(done_b), .auth_ok_o(auth_b)
  );

  logic [15:0] vec_a, vec_b, obs;
  assign vec_a = {ready_a, en_a, mode_a, round_a, bb_a, sb_a, be_a, se_a, pt_a, busy_a, done_a, auth_a};
  assign vec_b = {ready_b, en_b, mode_b, round_b, bb_b, sb_b, be_b, se_b, pt_b, busy_b, done_b, auth_b};
  assign obs   = use_b ? vec_b : vec_a;

  function automatic logic [15:0] ev(input logic rdy, en, md, input logic [3:0] rnd,
                                     input logic bb, input logic [1:0] sb, input logic be, se,
                                     input logic pt, bsy, dn, au);
    return {rdy, en, md, rnd, bb, sb, be, se, pt, bsy, dn, au};
  endfunction

  task automatic chk(input string tag, input logic [15:0] exp, input logic [15:0] mask);
    total++;
    assert ((obs & mask) === (exp & mask))
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h (mask %h)", tag, obs & mask, exp & mask, mask);
    end
  endtask

  task automatic step(input string tag, input logic [15:0] exp, input logic [15:0] mask);
    @(negedge clk);
    chk(tag, exp, mask);
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    start_a = use_b ? 1'b0 : v;
    start_b = use_b ? v : 1'b0;
  endtask

  // One host block handshake: optional forced stalls, random stalls, then the transfer cycle.
  task automatic wait_block(input string tag, input int forced, input int vprob,
                            input logic [15:0] xfer_exp);
    int stalls = 0;
    logic v;
    forever begin
      if (stalls < forced)     v = 1'b0;
      else if (vprob == 0)     v = 1'b1;
      else if (stalls >= 20)   v = 1'b1;
      else                     v = ($urandom_range(0, vprob) != 0);
      valid = v;
      if (v) break;
      step({tag, "_stall"}, ev(1, 0, 0, 0, 1, 2'b00, 1, 0, 0, 1, 0, 0), M_IDLE);
      stalls++;
    end
    step({tag, "_xfer"}, xfer_exp, M_FULL);
    valid = 1'b0;
  endtask

  task automatic run_msg(input int nb_ad, input int nb_ct, input logic tm, input logic auth_prev,
                         input int vprob, input int ct_stall, input int abort_r);
    aborted = 1'b0;
    set_start(1'b1);
    valid = 1'(($urandom_range(0, 1)));
    step("idle_start", ev(0, 0, 0, 0, 1, 2'b00, 1, 0, 0, 0, 0, auth_prev), M_IDLE);
    set_start(1'b0);

    for (int r = 0; r < 12; r++) begin
      valid = 1'(($urandom_range(0, 1)));
      step("init", ev(0, 1, (r != 0), 4'(r), 1, 2'b00, (r != 11), 0, 0, 1, 0, 0), M_FULL);
    end
    valid = 1'b0;

    for (int a = 0; a < nb_ad; a++) begin
      wait_block("ad", 0, vprob, ev(1, 1, 1, 4'd6, 0, 2'b00, 1, 0, 0, 1, 0, 0));
      for (int r = 7; r <= 11; r++) begin
        set_start(1'(($urandom_range(0, 1))));
        step("ad_run", ev(0, 1, 1, 4'(r), 1, 2'b00,
                          !((r == 11) && (a == nb_ad - 1)), (r == 11) && (a == nb_ad - 1),
                          0, 1, 0, 0), M_FULL);
      end
      set_start(1'b0);
    end

    for (int c = 0; c < nb_ct; c++) begin
      if (c == nb_ct - 1) begin
        wait_block("ct_last", ct_stall, vprob, ev(1, 1, 1, 4'd0, 0, 2'b11, 1, 0, 1, 1, 0, 0));
      end else begin
        wait_block("ct", ct_stall, vprob, ev(1, 1, 1, 4'd6, 0, 2'b01, 1, 0, 1, 1, 0, 0));
        for (int r = 7; r <= 11; r++)
          step("ct_run", ev(0, 1, 1, 4'(r), 1, 2'b00, 1, 0, 0, 1, 0, 0), M_FULL);
      end
    end

    for (int r = 1; r <= 11; r++) begin
      if (r == abort_r) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", ev(0, 0, 0, 4'd0, 1, 2'b00, 1, 0, 0, 0, 0, 0), M_FULL);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        aborted = 1'b1;
        return;
      end
      step("final", ev(0, 1, 1, 4'(r), 1, 2'b00, (r != 11), 0, 0, 1, 0, 0), M_FULL);
    end

    tagm = tm;
    step("tag", ev(0, 0, 0, 0, 1, 2'b00, 1, 0, 0, 1, 1, 0), M_IDLE);
    tagm = 1'(($urandom_range(0, 1)));
    valid = 1'(($urandom_range(0, 1)));
    step("idle_after", ev(0, 0, 0, 0, 1, 2'b00, 1, 0, 0, 0, 0, tm), M_IDLE);
    valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; valid = 1'b0; tagm = 1'b0;
    #12;
    use_b = 1'b0; #1;
    chk("reset_a", ev(0, 0, 0, 4'd0, 1, 2'b00, 1, 0, 0, 0, 0, 0), M_FULL);
    use_b = 1'b1; #1;
    chk("reset_b", ev(0, 0, 0, 4'd0, 1, 2'b00, 1, 0, 0, 0, 0, 0), M_FULL);
    use_b = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("idle_post_reset", ev(0, 0, 0, 4'd0, 1, 2'b00, 1, 0, 0, 0, 0, 0), M_FULL);

    // Nominal run, then random stalls with failing tag, then a fixed 5-cycle CT stall.
    run_msg(1, 4, 1'b1, 1'b0, 0, 0, 0);
    run_msg(1, 4, 1'b0, 1'b1, 3, 0, 0);
    run_msg(1, 4, 1'b1, 1'b0, 0, 5, 0);

    // Reset in FINAL round 5, then a clean nominal rerun.
    run_msg(1, 4, 1'b1, 1'b1, 0, 0, 5);
    total++;
    assert (aborted === 1'b1)
    else begin
      bad++;
      $error("FAIL abort_reached: observed=%0b expected=1", aborted);
    end
    step("idle_after_abort", ev(0, 0, 0, 4'd0, 1, 2'b00, 1, 0, 0, 0, 0, 0), M_FULL);
    run_msg(1, 4, 1'b1, 1'b0, 0, 0, 0);

    for (int k = 0; k < 3; k++)
      run_msg(1, 4, 1'(k[0]), (k == 0) ? 1'b1 : 1'(~k[0]), 2, 0, 0);

    // Two AD blocks, single-block ciphertext.
    use_b = 1'b1;
    run_msg(2, 1, 1'b1, 1'b0, 0, 0, 0);
    run_msg(2, 1, 1'b0, 1'b1, 2, 3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
